// File: rtl/motion_detect_core_p_pkg.sv
// Shared types and helpers for the parametrised motion-detect datapath.
package motion_detect_pkg;

  typedef enum logic [1:0] {
    MD_MASK  = 2'd0,
    MD_DIFF  = 2'd1,
    MD_GATED = 2'd2,
    MD_RSVD  = 2'd3
  } md_mode_e;

  localparam int MD_DEFAULT_THR = 0;

  function automatic int md_frame_pixels(input int width, input int height);
    return width * height;
  endfunction

endpackage

// File: rtl/motion_detect_core_p_if.sv
// FIFO-side bundle of the motion-detect core: two FWFT input FIFOs and one output FIFO.
// Pixels are packed {R, G, B} with R in the most significant channel.
interface motion_detect_core_p_if #(
  parameter int CW = 8
);

  logic            cur_rd_en;
  logic            cur_empty;
  logic [3*CW-1:0] cur_dout;
  logic            base_rd_en;
  logic            base_empty;
  logic [3*CW-1:0] base_dout;
  logic            out_wr_en;
  logic            out_full;
  logic [CW-1:0]   out_din;

  modport master (
    output cur_rd_en,
    input  cur_empty,
    input  cur_dout,
    output base_rd_en,
    input  base_empty,
    input  base_dout,
    output out_wr_en,
    input  out_full,
    output out_din
  );

  modport slave (
    input  cur_rd_en,
    output cur_empty,
    output cur_dout,
    input  base_rd_en,
    output base_empty,
    output base_dout,
    input  out_wr_en,
    output out_full,
    input  out_din
  );

endinterface

// File: rtl/motion_detect_core_p_rgb2gray.sv
// Registered RGB-to-gray stage: gray = (R+G+B)/3, truncating, loaded only when en is high.
module md_rgb2gray #(
  parameter int CW = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            en,
  input  logic [3*CW-1:0] rgb,
  output logic [CW-1:0]   gray_q
);

  logic [CW-1:0] chan [3];
  logic [CW+1:0] sum;
  logic [CW-1:0] gray_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = rgb[gi*CW +: CW];
  end

  always_comb begin
    sum    = (CW+2)'(chan[0]) + (CW+2)'(chan[1]) + (CW+2)'(chan[2]);
    gray_d = gray_q;
    if (en) begin
      gray_d = CW'(sum / (CW+2)'(3));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

endmodule

// File: rtl/motion_detect_core_p.sv
// Motion-detect core: pops paired pixels, thresholds |gray_cur - gray_base|, pushes one pixel per pair.
// Define MD_MOTION_COUNT_EN to add the per-frame motion_count output.
module motion_detect_core_p
  import motion_detect_pkg::*;
#(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int CW         = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  motion_detect_core_p_if.master fifo,
  input  logic [CW-1:0]          threshold,
  input  logic [1:0]             mode,
  output logic                   frame_done
`ifdef MD_MOTION_COUNT_EN
  ,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] motion_count
`endif
);

  localparam int NPIX  = md_frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

  logic en, pop, wr, last_wr, first_pop;

  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d, wcnt_q, wcnt_d;

  logic [CW-1:0] thr_l_q, thr_l_d;
  md_mode_e      mode_l_q, mode_l_d;
  logic [CW-1:0] cfg_thr;
  md_mode_e      cfg_mode;

  logic [CW-1:0] gray_c1, gray_b1;
  logic [CW-1:0] thr1_q, thr1_d;
  md_mode_e      mode1_q, mode1_d;

  logic [CW-1:0] diff2_q, diff2_d, gc2_q, gc2_d;
  logic          hit2_q, hit2_d;
  md_mode_e      mode2_q, mode2_d;

  logic [CW-1:0] out3_q, out3_d;

  // Holding on a full output FIFO only matters when S3 actually holds a pixel.
  assign en        = !(v3_q && fifo.out_full);
  assign pop       = !reset && en && !fifo.cur_empty && !fifo.base_empty;
  assign wr        = !reset && v3_q && !fifo.out_full;
  assign last_wr   = wr && (wcnt_q == LAST_PIX);
  assign first_pop = pop && (pcnt_q == '0);

  assign fifo.cur_rd_en  = pop;
  assign fifo.base_rd_en = pop;
  assign fifo.out_wr_en  = wr;
  assign fifo.out_din    = out3_q;
  assign frame_done      = last_wr;

  md_rgb2gray #(.CW(CW)) u_gray_cur (
    .clock  (clock),
    .reset  (reset),
    .en     (pop),
    .rgb    (fifo.cur_dout),
    .gray_q (gray_c1)
  );

  md_rgb2gray #(.CW(CW)) u_gray_base (
    .clock  (clock),
    .reset  (reset),
    .en     (pop),
    .rgb    (fifo.base_dout),
    .gray_q (gray_b1)
  );

  // The pop counter marks frame starts on the input side, so a new frame can latch
  // its config while the previous frame's tail is still draining.
  always_comb begin
    pcnt_d   = pcnt_q;
    wcnt_d   = wcnt_q;
    thr_l_d  = thr_l_q;
    mode_l_d = mode_l_q;
    cfg_thr  = thr_l_q;
    cfg_mode = mode_l_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    v3_d     = v3_q;
    thr1_d   = thr1_q;
    mode1_d  = mode1_q;
    diff2_d  = diff2_q;
    hit2_d   = hit2_q;
    gc2_d    = gc2_q;
    mode2_d  = mode2_q;
    out3_d   = out3_q;

    if (first_pop) begin
      thr_l_d  = threshold;
      mode_l_d = md_mode_e'(mode);
      cfg_thr  = threshold;
      cfg_mode = md_mode_e'(mode);
    end

    if (pop) begin
      pcnt_d = (pcnt_q == LAST_PIX) ? '0 : pcnt_q + CNT_W'(1);
    end
    if (wr) begin
      wcnt_d = (wcnt_q == LAST_PIX) ? '0 : wcnt_q + CNT_W'(1);
    end

    if (en) begin
      v1_d = pop;
      v2_d = v1_q;
      v3_d = v2_q;
      if (pop) begin
        thr1_d  = cfg_thr;
        mode1_d = cfg_mode;
      end
      if (v1_q) begin
        diff2_d = (gray_c1 >= gray_b1) ? gray_c1 - gray_b1 : gray_b1 - gray_c1;
        hit2_d  = ((gray_c1 >= gray_b1) ? gray_c1 - gray_b1 : gray_b1 - gray_c1) > thr1_q;
        gc2_d   = gray_c1;
        mode2_d = mode1_q;
      end
      if (v2_q) begin
        case (mode2_q)
          MD_DIFF:  out3_d = diff2_q;
          MD_GATED: out3_d = hit2_q ? gc2_q : '0;
          default:  out3_d = {CW{hit2_q}};
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q   <= '0;
      wcnt_q   <= '0;
      thr_l_q  <= CW'(MD_DEFAULT_THR);
      mode_l_q <= MD_MASK;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      thr1_q   <= '0;
      mode1_q  <= MD_MASK;
      diff2_q  <= '0;
      hit2_q   <= 1'b0;
      gc2_q    <= '0;
      mode2_q  <= MD_MASK;
      out3_q   <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      wcnt_q   <= wcnt_d;
      thr_l_q  <= thr_l_d;
      mode_l_q <= mode_l_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      thr1_q   <= thr1_d;
      mode1_q  <= mode1_d;
      diff2_q  <= diff2_d;
      hit2_q   <= hit2_d;
      gc2_q    <= gc2_d;
      mode2_q  <= mode2_d;
      out3_q   <= out3_d;
    end
  end

`ifdef MD_MOTION_COUNT_EN
  logic             hit3_q, hit3_d;
  logic [CNT_W-1:0] macc_q, macc_d, mcount_q, mcount_d;

  // The frame's last pixel is folded into the published total, not into the next frame.
  always_comb begin
    hit3_d   = hit3_q;
    macc_d   = macc_q;
    mcount_d = mcount_q;
    if (en && v2_q) begin
      hit3_d = hit2_q;
    end
    if (wr) begin
      if (last_wr) begin
        mcount_d = macc_q + CNT_W'(hit3_q);
        macc_d   = '0;
      end else begin
        macc_d   = macc_q + CNT_W'(hit3_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit3_q   <= 1'b0;
      macc_q   <= '0;
      mcount_q <= '0;
    end else begin
      hit3_q   <= hit3_d;
      macc_q   <= macc_d;
      mcount_q <= mcount_d;
    end
  end

  assign motion_count = mcount_q;
`endif

endmodule

// File: tb/tb_motion_detect_core_p.sv
// Directed bench for motion_detect_core_p on a 4x2 frame: table of pixels with hand-computed outputs.
module tb_motion_detect_core_p;
  import motion_detect_pkg::*;

  localparam int CW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NP = 8;
  localparam int NV = 40;

  typedef struct {
    logic [23:0] cur;
    logic [23:0] base;
    logic [7:0]  thr;
    logic [1:0]  md;
    logic [7:0]  exp;
    bit          hit;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] threshold = '0;
  logic [1:0] mode = '0;
  logic       frame_done;
`ifdef MD_MOTION_COUNT_EN
  logic [$clog2(NP+1)-1:0] motion_count;
`endif

  motion_detect_core_p_if #(.CW(CW)) fifo_if ();

  motion_detect_core_p #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CW(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .fifo         (fifo_if),
    .threshold    (threshold),
    .mode         (mode),
    .frame_done   (frame_done)
`ifdef MD_MOTION_COUNT_EN
    ,
    .motion_count (motion_count)
`endif
  );

  always #5 clock = ~clock;

  vec_t        tv [NV];
  logic [23:0] qc[$], qb[$];
  logic [7:0]  qt[$], qe[$];
  logic [1:0]  qm[$];
  bit          qd[$];
  int          qmc[$];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, wr_cnt = 0, first_pop = -1, first_wr = -1, stall_left = 0;
  bit rst_req = 1'b1, cur_hold = 1'b0, chk_data = 1'b0, fd_prev = 1'b0;

  function automatic logic [23:0] g(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {b, b, b};
  endfunction

  function automatic vec_t mk(input logic [23:0] c, input logic [23:0] b,
                              input int t, input int m, input int e, input int h);
    vec_t r;
    r.cur = c; r.base = b; r.thr = 8'(t); r.md = 2'(m); r.exp = 8'(e); r.hit = (h != 0);
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic push_pix(input logic [23:0] c, input logic [23:0] b, input logic [7:0] t, input logic [1:0] m);
    qc.push_back(c); qb.push_back(b); qt.push_back(t); qm.push_back(m);
  endtask

  // One clock: drive FIFO-side inputs at the falling edge, then observe and act on the handshakes.
  task automatic cycle();
    logic [7:0] e;
    bit d;
    int emc;
    @(negedge clock);
    reset               = rst_req;
    fifo_if.cur_empty   = cur_hold || (qc.size() == 0);
    fifo_if.base_empty  = (qb.size() == 0);
    fifo_if.cur_dout    = (qc.size() != 0) ? qc[0] : '0;
    fifo_if.base_dout   = (qb.size() != 0) ? qb[0] : '0;
    fifo_if.out_full    = (stall_left > 0);
    if (qt.size() != 0) begin
      threshold = qt[0];
      mode      = qm[0];
    end
    #1;
`ifdef MD_MOTION_COUNT_EN
    if (fd_prev && qmc.size() != 0) begin
      emc = qmc.pop_front();
      chk(int'(motion_count) == emc, "motion_count", motion_count, emc);
    end
`endif
    fd_prev = frame_done;
    if (stall_left > 0) begin
      chk(!fifo_if.cur_rd_en && !fifo_if.base_rd_en && !fifo_if.out_wr_en, "stall_quiet",
          {fifo_if.cur_rd_en, fifo_if.base_rd_en, fifo_if.out_wr_en}, 0);
      stall_left--;
    end
    if (fifo_if.cur_rd_en && qc.size() != 0) begin
      if (first_pop < 0) first_pop = cyc;
      void'(qc.pop_front()); void'(qb.pop_front()); void'(qt.pop_front()); void'(qm.pop_front());
    end
    if (fifo_if.out_wr_en) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      if (chk_data && qe.size() != 0) begin
        e = qe.pop_front();
        d = qd.pop_front();
        chk(fifo_if.out_din == e, $sformatf("out_din[%0d]", wr_cnt), fifo_if.out_din, e);
        chk(frame_done == d, $sformatf("frame_done[%0d]", wr_cnt), frame_done, d);
      end
    end else if (frame_done) begin
      chk(1'b0, "frame_done_without_write", 1, 0);
    end
    cyc++;
  endtask

  initial begin
    int hsum;
    int fd_at;
    bit stalled;
    // Frame 0: MASK, thr 20 latched (40 driven afterwards is ignored)
    tv[0]  = mk(g(90),  g(60),  20, 0, 8'hFF, 1);
    tv[1]  = mk(g(80),  g(60),  40, 0, 8'h00, 0);
    tv[2]  = mk(g(60),  g(81),  40, 0, 8'hFF, 1);
    tv[3]  = mk(24'hFF0000, g(0), 40, 0, 8'hFF, 1);
    tv[4]  = mk(g(10),  g(10),  40, 0, 8'h00, 0);
    tv[5]  = mk(24'h010100, g(0), 40, 0, 8'h00, 0);
    tv[6]  = mk(g(200), g(0),   40, 0, 8'hFF, 1);
    tv[7]  = mk(g(0),   g(255), 40, 0, 8'hFF, 1);
    // Frame 1: MASK, thr 40
    tv[8]  = mk(g(90),  g(60),  40, 0, 8'h00, 0);
    tv[9]  = mk(g(100), g(59),  40, 0, 8'hFF, 1);
    tv[10] = mk(g(100), g(60),  40, 0, 8'h00, 0);
    tv[11] = mk(24'h646566, g(60), 40, 0, 8'hFF, 1);
    tv[12] = mk(24'h020201, g(0), 40, 0, 8'h00, 0);
    tv[13] = mk(g(255), g(255), 40, 0, 8'h00, 0);
    tv[14] = mk(g(50),  g(10),  40, 0, 8'h00, 0);
    tv[15] = mk(g(5),   g(46),  40, 0, 8'hFF, 1);
    // Frame 2: DIFF, thr 20 (GATED driven afterwards is ignored)
    tv[16] = mk(g(10),  g(200), 20, 1, 190, 1);
    tv[17] = mk(g(200), g(10),  20, 2, 190, 1);
    tv[18] = mk(g(30),  g(30),  20, 2, 0,   0);
    tv[19] = mk(g(25),  g(5),   20, 2, 20,  0);
    tv[20] = mk(g(26),  g(5),   20, 2, 21,  1);
    tv[21] = mk(g(255), g(0),   20, 2, 255, 1);
    tv[22] = mk(g(7),   g(0),   20, 2, 7,   0);
    tv[23] = mk(24'h0000FF, 24'h00FF00, 20, 2, 0, 0);
    // Frame 3: GATED, thr 50
    tv[24] = mk(24'hFF0000, g(0), 50, 2, 85, 1);
    tv[25] = mk(g(90),  g(60),  50, 2, 0,   0);
    tv[26] = mk(g(120), g(0),   50, 2, 120, 1);
    tv[27] = mk(g(60),  g(120), 50, 2, 60,  1);
    tv[28] = mk(g(100), g(50),  50, 2, 0,   0);
    tv[29] = mk(g(100), g(49),  50, 2, 100, 1);
    tv[30] = mk(g(0),   g(255), 50, 2, 0,   1);
    tv[31] = mk(g(33),  g(33),  50, 2, 0,   0);
    // Frame 4: reserved mode 3 behaves as MASK, thr 100, no hits
    tv[32] = mk(g(0),   g(100), 100, 3, 0, 0);
    tv[33] = mk(g(50),  g(0),   100, 3, 0, 0);
    tv[34] = mk(g(100), g(0),   100, 3, 0, 0);
    tv[35] = mk(g(1),   g(0),   100, 3, 0, 0);
    tv[36] = mk(g(200), g(150), 100, 3, 0, 0);
    tv[37] = mk(g(10),  g(90),  100, 3, 0, 0);
    tv[38] = mk(g(255), g(200), 100, 3, 0, 0);
    tv[39] = mk(g(7),   g(9),   100, 3, 0, 0);

    hsum = 0;
    for (int i = 0; i < NV; i++) begin
      push_pix(tv[i].cur, tv[i].base, tv[i].thr, tv[i].md);
      qe.push_back(tv[i].exp);
      qd.push_back((i % NP) == NP - 1);
      hsum += int'(tv[i].hit);
      if ((i % NP) == NP - 1) begin
        qmc.push_back(hsum);
        hsum = 0;
      end
    end

    fifo_if.cur_empty = 1'b1; fifo_if.base_empty = 1'b1; fifo_if.out_full = 1'b0;
    fifo_if.cur_dout = '0;    fifo_if.base_dout = '0;

    // Reset state with data waiting in both FIFOs
    cycle(); cycle();
    chk(!fifo_if.cur_rd_en && !fifo_if.base_rd_en, "reset_rd_en", fifo_if.cur_rd_en, 0);
    chk(!fifo_if.out_wr_en, "reset_wr_en", fifo_if.out_wr_en, 0);
    chk(fifo_if.out_din == 8'h00, "reset_out_din", fifo_if.out_din, 0);
    chk(!frame_done, "reset_frame_done", frame_done, 0);
`ifdef MD_MOTION_COUNT_EN
    chk(motion_count == '0, "reset_motion_count", motion_count, 0);
`endif

    // Current FIFO empty, base non-empty: neither side may pop
    rst_req = 1'b0;
    cur_hold = 1'b1;
    repeat (3) begin
      cycle();
      chk(!fifo_if.cur_rd_en && !fifo_if.base_rd_en, "one_empty_no_pop",
          {fifo_if.cur_rd_en, fifo_if.base_rd_en}, 0);
    end

    // Stream 5 back-to-back frames, with a 5-cycle output stall after the 10th write
    cur_hold = 1'b0;
    chk_data = 1'b1;
    stalled  = 1'b0;
    while (wr_cnt < NV && cyc < 400) begin
      cycle();
      if (wr_cnt == 10 && !stalled) begin
        stalled    = 1'b1;
        stall_left = 5;
      end
    end
    chk(wr_cnt == NV, "stream_writes", wr_cnt, NV);
    chk(first_wr - first_pop == 3, "pop_to_write_latency", first_wr - first_pop, 3);

    // Reset after the 5th write of a new frame; the next frame_done needs 8 fresh writes
    chk_data = 1'b0;
    for (int i = 0; i < 20; i++) push_pix(g(90), g(0), 8'd20, 2'd0);
    qmc.push_back(8);
    wr_cnt = 0;
    while (wr_cnt < 5 && cyc < 600) cycle();
    chk(wr_cnt == 5, "pre_reset_writes", wr_cnt, 5);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    chk(!fifo_if.out_wr_en, "post_reset_wr_en", fifo_if.out_wr_en, 0);
    chk(fifo_if.out_din == 8'h00, "post_reset_out_din", fifo_if.out_din, 0);
    chk(!frame_done, "post_reset_frame_done", frame_done, 0);
    wr_cnt = 0;
    fd_at  = -1;
    while (fd_at < 0 && cyc < 800) begin
      cycle();
      if (frame_done && fifo_if.out_wr_en) fd_at = wr_cnt;
    end
    chk(fd_at == 8, "frame_done_after_reset", fd_at, 8);
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
